// File: rtl/arbiter_n_to_1_request.sv
// Round-robin N-to-1 MemoryPacket arbiter: 2-deep skid buffer per requester,
// burst-locked grant, registered output. Define ARB_STARVE_GUARD_EN for starvation override.
package arbiter_n_to_1_request_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } MemoryPayload;

    typedef struct packed {
        logic         valid;
        MemoryPayload payload;
    } MemoryPacket;

endpackage

module arbiter_n_to_1_request
    import arbiter_n_to_1_request_pkg::*;
#(
    parameter int unsigned NUM_MEMORY_REQUESTOR = 2,
    parameter int unsigned MAX_BURST            = 4,
    parameter int unsigned SETUP_CYCLES         = 8,
    parameter int unsigned STARVE_LIMIT         = 64
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  MemoryPacket                     request_in [NUM_MEMORY_REQUESTOR],
    output logic [NUM_MEMORY_REQUESTOR-1:0] request_in_ready,
    output MemoryPacket                     request_out,
    input  logic                            request_out_ready,
    output logic [NUM_MEMORY_REQUESTOR-1:0] grant_out,
    output logic                            fifo_setup_signal
);

    localparam int unsigned N  = NUM_MEMORY_REQUESTOR;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned SW = (SETUP_CYCLES < 2) ? 1 : $clog2(SETUP_CYCLES + 1);
    localparam logic [7:0]  MAX_B = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        S_SETUP,
        S_IDLE,
        S_GRANT,
        S_STALL
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] setup_cnt_q, setup_cnt_d;

    logic [1:0]    cnt_q  [N];
    logic [1:0]    cnt_d  [N];
    MemoryPayload  head_q [N];
    MemoryPayload  head_d [N];
    MemoryPayload  tail_q [N];
    MemoryPayload  tail_d [N];

    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_grant_q, out_grant_d;
    MemoryPayload  out_pay_q, out_pay_d;
    logic [IW-1:0] last_q, last_d;
    logic [7:0]    burst_q, burst_d;

    logic [N-1:0]  nonempty;
    logic [N-1:0]  push;
    logic [N-1:0]  pop;
    logic          active;
    logic          load_ok;
    logic          arb_en;
    logic          keep;
    logic          found;
    logic          issue;
    logic [IW-1:0] rr_sel;
    logic [IW-1:0] rr_idx;
    logic [IW-1:0] gsel;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            nonempty[i]         = (cnt_q[i] != 2'd0);
            request_in_ready[i] = (cnt_q[i] != 2'd2) && (state_q != S_SETUP);
            push[i]             = request_in[i].valid & request_in_ready[i];
        end
    end

    assign active  = (state_q != S_SETUP);
    assign load_ok = ~out_valid_q | request_out_ready;
    assign arb_en  = load_ok & active;

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0]    wait_q [N];
    logic [7:0]    wait_d [N];
    logic [N-1:0]  starving;
    logic          st_found;
    logic [IW-1:0] st_sel;
    logic [IW-1:0] st_idx;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            starving[i] = nonempty[i] && ({24'd0, wait_q[i]} >= STARVE_LIMIT);
        end
        st_found = 1'b0;
        st_sel   = last_q;
        st_idx   = last_q;
        // Walk downward so the nearest starving requester after last_q wins.
        for (int k = int'(N); k >= 1; k--) begin
            st_idx = IW'((int'(last_q) + k) % int'(N));
            if (starving[st_idx]) begin
                st_found = 1'b1;
                st_sel   = st_idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            wait_d[i] = wait_q[i];
            if (pop[i]) begin
                wait_d[i] = 8'd0;
            end else if (nonempty[i] && (wait_q[i] != 8'hff)) begin
                wait_d[i] = wait_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                wait_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end
`endif

    always_comb begin
        found  = 1'b0;
        rr_sel = last_q;
        rr_idx = last_q;
        for (int k = int'(N); k >= 1; k--) begin
            rr_idx = IW'((int'(last_q) + k) % int'(N));
            if (nonempty[rr_idx]) begin
                found  = 1'b1;
                rr_sel = rr_idx;
            end
        end
        keep = (burst_q < MAX_B) && nonempty[last_q];
        gsel = keep ? last_q : rr_sel;
`ifdef ARB_STARVE_GUARD_EN
        if (st_found) begin
            keep = 1'b0;
            gsel = st_sel;
        end
`endif
        issue = arb_en & (keep | found);
        for (int i = 0; i < int'(N); i++) begin
            pop[i] = issue && (gsel == IW'(i));
        end
    end

    // A pop and a push in the same cycle both land; FIFO order via head/tail shift.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            head_d[i] = head_q[i];
            tail_d[i] = tail_q[i];
            cnt_d[i]  = cnt_q[i];
            if (pop[i]) begin
                head_d[i] = tail_q[i];
                cnt_d[i]  = cnt_d[i] - 2'd1;
            end
            if (push[i]) begin
                if (cnt_d[i] == 2'd0) begin
                    head_d[i] = request_in[i].payload;
                end else begin
                    tail_d[i] = request_in[i].payload;
                end
                cnt_d[i] = cnt_d[i] + 2'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        out_valid_d = out_valid_q;
        out_grant_d = out_grant_q;
        out_pay_d   = out_pay_q;
        last_d      = last_q;
        burst_d     = burst_q;

        if (arb_en) begin
            out_valid_d = issue;
            out_grant_d = '0;
            if (issue) begin
                out_grant_d[gsel] = 1'b1;
                out_pay_d         = head_q[gsel];
                last_d            = gsel;
                burst_d           = keep ? (burst_q + 8'd1) : 8'd1;
            end
        end

        unique case (state_q)
            S_SETUP: begin
                if (setup_cnt_q <= SW'(1)) begin
                    state_d     = S_IDLE;
                    setup_cnt_d = '0;
                end else begin
                    setup_cnt_d = setup_cnt_q - SW'(1);
                end
            end
            S_IDLE: begin
                if (issue) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT, S_STALL: begin
                if (!load_ok) begin
                    state_d = S_STALL;
                end else begin
                    state_d = issue ? S_GRANT : S_IDLE;
                end
            end
            default: state_d = S_SETUP;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= S_SETUP;
            setup_cnt_q <= SW'(SETUP_CYCLES);
            out_valid_q <= 1'b0;
            out_grant_q <= '0;
            last_q      <= IW'(N - 1);
            burst_q     <= 8'd0;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= 2'd0;
            end
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            out_valid_q <= out_valid_d;
            out_grant_q <= out_grant_d;
            last_q      <= last_d;
            burst_q     <= burst_d;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Payload storage carries no reset; validity lives in cnt_q / out_valid_q.
    always_ff @(posedge ap_clk) begin
        out_pay_q <= out_pay_d;
        for (int i = 0; i < int'(N); i++) begin
            head_q[i] <= head_d[i];
            tail_q[i] <= tail_d[i];
        end
    end

    always_comb begin
        request_out         = '0;
        request_out.valid   = out_valid_q;
        request_out.payload = out_pay_q;
    end

    assign grant_out         = out_grant_q;
    assign fifo_setup_signal = (state_q == S_SETUP);

endmodule

// File: tb/tb_arbiter_n_to_1_request.sv
// Randomized scoreboard bench for arbiter_n_to_1_request against a queue-based model.
module tb_arbiter_n_to_1_request;
    import arbiter_n_to_1_request_pkg::*;

    localparam int N  = 2;
    localparam int SC = 8;
`ifdef ARB_STARVE_GUARD_EN
    localparam int MB = 255;
    localparam int SL = 10;
`else
    localparam int MB = 4;
    localparam int SL = 64;
`endif

    typedef struct {
        int           g;
        MemoryPayload p;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    MemoryPacket  req_in [N];
    logic [N-1:0] req_rdy;
    logic [N-1:0] grant;
    MemoryPacket  req_out;
    logic         out_rdy = 1'b1;
    logic         setup;

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    int seq    = 0;

    MemoryPayload mq [N][$];
    exp_t         sb [$];
    int           m_last;
    int           m_burst;
    int           m_setup;
    bit           m_ov;
    int           m_wait [N];

    always #5 clk = ~clk;

    arbiter_n_to_1_request #(
        .NUM_MEMORY_REQUESTOR(N),
        .MAX_BURST(MB),
        .SETUP_CYCLES(SC),
        .STARVE_LIMIT(SL)
    ) dut (
        .ap_clk(clk),
        .ap_rst_n(rst_n),
        .request_in(req_in),
        .request_in_ready(req_rdy),
        .request_out(req_out),
        .request_out_ready(out_rdy),
        .grant_out(grant),
        .fifo_setup_signal(setup)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: per-requester queues, burst-lock then round-robin by plain arithmetic.
    task automatic model_step();
        bit   act;
        bit   keep;
        int   pick;
        int   j;
        bit   rdy [N];
        bit   ne [N];
        exp_t e;
        act = (m_setup == 0);
        for (int i = 0; i < N; i++) begin
            rdy[i] = act && (mq[i].size() < 2);
            ne[i]  = (mq[i].size() > 0);
        end
        pick = -1;
        keep = 1'b0;
        if (act && (!m_ov || out_rdy)) begin
`ifdef ARB_STARVE_GUARD_EN
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (pick < 0 && ne[j] && m_wait[j] >= SL) pick = j;
            end
`endif
            if (pick < 0 && m_burst < MB && ne[m_last]) keep = 1'b1;
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (!keep && pick < 0 && ne[j]) pick = j;
            end
            if (keep) begin
                pick = m_last;
                m_burst++;
            end else if (pick >= 0) begin
                m_burst = 1;
            end
            if (pick >= 0) begin
                e.g = pick;
                e.p = mq[pick].pop_front();
                sb.push_back(e);
                m_last = pick;
                m_ov   = 1'b1;
            end else begin
                m_ov = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i == pick) m_wait[i] = 0;
            else if (ne[i] && m_wait[i] < 255) m_wait[i]++;
        end
        for (int i = 0; i < N; i++) begin
            if (req_in[i].valid && rdy[i]) mq[i].push_back(req_in[i].payload);
        end
        if (m_setup > 0) m_setup--;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                m_wait[i] = 0;
            end
            sb.delete();
            m_ov    = 1'b0;
            m_last  = N - 1;
            m_burst = 0;
            m_setup = SC;
        end else begin
            model_step();
        end
    end

    // Monitor: compare presented beat with scoreboard head; pop on handshake.
    always @(negedge clk) begin
        logic [N-1:0] er;
        logic [N-1:0] eg;
        for (int i = 0; i < N; i++) begin
            er[i] = (m_setup == 0) && (mq[i].size() < 2);
        end
        chk("setup_flag", 64'(setup), 64'(m_setup > 0));
        chk("in_ready", 64'(req_rdy), 64'(er));
        chk("out_valid", 64'(req_out.valid), 64'(m_ov));
        if (req_out.valid) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                eg = '0;
                eg[sb[0].g] = 1'b1;
                chk("grant", 64'(grant), 64'(eg));
                chk("payload", req_out.payload, sb[0].p);
                if (out_rdy) begin
                    void'(sb.pop_front());
                    beats++;
                end
            end
        end else begin
            chk("grant_idle", 64'(grant), 64'd0);
        end
    end

    task automatic cycle(input logic [N-1:0] v, input logic r);
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            req_in[i].valid        = v[i];
            req_in[i].payload.addr = {8'(i), 24'(seq)};
            req_in[i].payload.data = $urandom;
        end
        seq++;
        out_rdy = r;
    endtask

    initial begin
        int           n;
        int           b0;
        int           lat;
        logic [N-1:0] all1;
        all1 = '1;
        lat  = -1;
        for (int i = 0; i < N; i++) req_in[i] = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (setup) n++;
        end
        chk("setup_len", 64'(n), 64'(SC));
        chk("ready_after_setup", 64'(req_rdy), 64'(all1));
        chk("idle_valid", 64'(req_out.valid), 64'd0);

        repeat (8) cycle(2'b11, 1'b1);
        b0 = beats;
        repeat (30) cycle(2'b11, 1'b1);
        chk("throughput", 64'(beats - b0), 64'd30);

        repeat (6) cycle(2'b00, 1'b1);
        repeat (3) cycle(2'b10, 1'b1);
        repeat (5) cycle(2'b00, 1'b1);

        repeat (3) cycle(2'b11, 1'b1);
        repeat (5) cycle(2'b11, 1'b0);
        @(negedge clk);
        chk("full_ready_drop", 64'(req_rdy), 64'd0);
        repeat (10) cycle(2'b11, 1'b1);
        repeat (8) cycle(2'b00, 1'b1);

        repeat (400) cycle(N'($urandom), ($urandom_range(3) != 0));

        repeat (6) cycle(2'b11, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_reset_valid", 64'(req_out.valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_valid_drop", 64'(req_out.valid), 64'd0);
        chk("reset_grant_drop", 64'(grant), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (12) cycle(2'b11, 1'b1);
        repeat (200) cycle(N'($urandom), ($urandom_range(3) != 0));
        repeat (15) cycle(2'b00, 1'b1);

`ifdef ARB_STARVE_GUARD_EN
        repeat (20) cycle(2'b01, 1'b1);
        cycle(2'b11, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            cycle(2'b01, 1'b1);
            @(negedge clk);
            if (lat < 0 && grant == 2'b10) lat = k - 1;
        end
        chk("starve_latency_ok", 64'((lat >= 0) && (lat <= 11)), 64'd1);
        repeat (15) cycle(2'b00, 1'b1);
`endif

        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        chk("drain_buf_empty", 64'(mq[0].size() + mq[1].size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
